// File: rtl/router_pkg.sv
// Shared definitions for the router port blocks: header field layout,
// default widths/limits and the receive FSM state encoding.
package router_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int STALL_MAX_DEF = 31;

  // Header layout at the default width: {len, addr}
  localparam int LEN_MSB  = DATA_W_DEF - 1;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    DONE
  } rx_state_e;

endpackage

// File: rtl/router_rx_stats.sv
// Two saturating statistics counters: completed packets and errored packets.
module router_rx_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc_pkt,
  input  logic             inc_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (inc_pkt && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + 1'b1;
    if (inc_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: rtl/router_rx_port.sv
// Drains one router output port packet by packet and checks parity.
// Statistics counters are built only when RX_STATS_EN is defined.
module router_rx_port
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int START_DLY = 2,
  parameter int STALL_MAX = STALL_MAX_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  output logic              read_enb,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              pkt_done,
  output logic [5:0]        pkt_len,
  output logic [1:0]        pkt_addr,
  output logic              parity_err,
  output logic              pkt_abort,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  // Length field grows with DATA_W beyond the default layout.
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1 + (DATA_W - DATA_W_DEF);
  localparam int DLY_W   = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
  localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

  rx_state_e          state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [6:0]         issued_q, issued_d;
  logic [6:0]         capd_q, capd_d;
  logic               hdr_seen_q, hdr_seen_d;
  logic               rd_pend_q, rd_pend_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               byte_valid_q, byte_valid_d;
  logic [DATA_W-1:0]  byte_data_q, byte_data_d;
  logic               pkt_done_q, pkt_done_d;
  logic [5:0]         pkt_len_q, pkt_len_d;
  logic [1:0]         pkt_addr_q, pkt_addr_d;
  logic               parity_err_q, parity_err_d;
  logic               pkt_abort_q, pkt_abort_d;

  logic [6:0] total;
  logic       stall_hit;
  logic       capture;
  logic       final_cap;

  // Read strobe is combinational from vld_out so it can never outlive the port's data.
  assign total     = hdr_seen_q ? (7'(len_q) + 7'd2) : 7'd2;
  assign read_enb  = (state_q == READ) && vld_out && (issued_q < total);
  assign stall_hit = (state_q == READ) && !vld_out && (stall_q == STALL_W'(STALL_MAX - 1));
  assign capture   = (state_q == READ) && rd_pend_q && !stall_hit;
  assign final_cap = capture && hdr_seen_q && (capd_q == total - 7'd1);

  always_comb begin
    // NOTE: every signal gets its default first so no path can infer a latch.
    state_d      = state_q;
    dly_d        = dly_q;
    stall_d      = stall_q;
    issued_d     = issued_q;
    capd_d       = capd_q;
    hdr_seen_d   = hdr_seen_q;
    rd_pend_d    = read_enb;
    len_d        = len_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    pkt_done_d   = 1'b0;
    pkt_len_d    = pkt_len_q;
    pkt_addr_d   = pkt_addr_q;
    parity_err_d = parity_err_q;
    pkt_abort_d  = pkt_abort_q;

    case (state_q)
      IDLE: begin
        if (enable && vld_out) begin
          state_d    = WAIT;
          dly_d      = DLY_W'(START_DLY);
          stall_d    = '0;
          issued_d   = '0;
          capd_d     = '0;
          hdr_seen_d = 1'b0;
          len_d      = '0;
          addr_d     = '0;
          acc_d      = '0;
        end
      end
      WAIT: begin
        if (!vld_out)          state_d = IDLE;
        else if (dly_q == '0)  state_d = READ;
        else                   dly_d   = dly_q - 1'b1;
      end
      READ: begin
        if (read_enb) issued_d = issued_q + 7'd1;
        stall_d = vld_out ? '0 : stall_q + 1'b1;
        if (capture) begin
          byte_valid_d = 1'b1;
          byte_data_d  = data_out;
          capd_d       = capd_q + 7'd1;
          if (!hdr_seen_q) begin
            hdr_seen_d = 1'b1;
            len_d      = data_out[DATA_W-1:LEN_LSB];
            addr_d     = data_out[ADDR_MSB:ADDR_LSB];
            acc_d      = data_out;
          end else if (!final_cap) begin
            acc_d = acc_q ^ data_out;
          end
        end
        if (stall_hit || final_cap) begin
          state_d      = DONE;
          pkt_done_d   = 1'b1;
          pkt_abort_d  = stall_hit;
          parity_err_d = final_cap && (acc_q != data_out);
          pkt_len_d    = 6'(len_q);
          pkt_addr_d   = addr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      dly_q        <= '0;
      stall_q      <= '0;
      issued_q     <= '0;
      capd_q       <= '0;
      hdr_seen_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      acc_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      pkt_done_q   <= 1'b0;
      pkt_len_q    <= '0;
      pkt_addr_q   <= '0;
      parity_err_q <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its inputs.
      state_q      <= state_d;
      dly_q        <= dly_d;
      stall_q      <= stall_d;
      issued_q     <= issued_d;
      capd_q       <= capd_d;
      hdr_seen_q   <= hdr_seen_d;
      rd_pend_q    <= rd_pend_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      pkt_done_q   <= pkt_done_d;
      pkt_len_q    <= pkt_len_d;
      pkt_addr_q   <= pkt_addr_d;
      parity_err_q <= parity_err_d;
      pkt_abort_q  <= pkt_abort_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_addr   = pkt_addr_q;
  assign parity_err = parity_err_q;
  assign pkt_abort  = pkt_abort_q;

`ifdef RX_STATS_EN
  router_rx_stats #(.CNT_W(CNT_W)) u_stats (
    .clock     (clock),
    .resetn    (resetn),
    .inc_pkt   (pkt_done_q),
    .inc_err   (pkt_done_q && (parity_err_q || pkt_abort_q)),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_router_rx_port.sv
// Scoreboard bench for router_rx_port: a router FIFO model feeds packets, a
// monitor compares every captured byte and packet report against expectations.
module tb_router_rx_port;

  localparam int DATA_W    = 8;
  localparam int START_DLY = 2;
  localparam int STALL_MAX = 31;
  localparam int CNT_W     = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

`ifdef RX_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic              enable;
  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              read_enb;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              pkt_done;
  logic [5:0]        pkt_len;
  logic [1:0]        pkt_addr;
  logic              parity_err;
  logic              pkt_abort;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  err_count;

  router_rx_port #(
    .DATA_W(DATA_W), .START_DLY(START_DLY), .STALL_MAX(STALL_MAX), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .vld_out(vld_out),
    .data_out(data_out), .read_enb(read_enb), .byte_valid(byte_valid),
    .byte_data(byte_data), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .pkt_addr(pkt_addr), .parity_err(parity_err), .pkt_abort(pkt_abort),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         stall;   // vld_out low for this many cycles after this byte is read
    bit         flush;   // router drops the rest of the packet when the stall starts
    bit         last;
  } fbyte_t;

  typedef struct {
    int len;
    int addr;
    bit perr;
    bit abort;
  } exp_pkt_t;

  fbyte_t     fifo[$];
  exp_pkt_t   sb_pkt[$];
  logic [7:0] sb_byte[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_count, run, max_run, stall_left;
  int exp_pkts = 0;
  int exp_errs = 0;
  bit cnt_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    if (!STATS_ON) return 32'd0;
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // Router output port model: 1-cycle read latency, vld_out = not empty.
  initial begin : router_model
    bit     rd;
    fbyte_t b;
    vld_out = 1'b0; data_out = '0;
    rd_count = 0; run = 0; max_run = 0; stall_left = 0;
    forever begin
      @(negedge clock);
      rd = read_enb;
      if (rd) begin
        check("read_enb_without_vld", 32'(vld_out), 1);
        rd_count++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      @(posedge clock);
      #1;
      if (!resetn) begin
        fifo.delete();
        stall_left = 0;
      end else if (rd && fifo.size() > 0) begin
        b = fifo.pop_front();
        data_out = b.data;
        if (b.stall > 0) begin
          stall_left = b.stall;
          if (b.flush) while (!b.last && fifo.size() > 0) b = fifo.pop_front();
        end
      end else begin
        data_out = 8'($urandom);
      end
      if (stall_left > 0) begin
        vld_out = 1'b0;
        stall_left--;
      end else begin
        vld_out = (fifo.size() > 0);
      end
    end
  end

  // Monitor: compares DUT outputs whenever they are presented.
  initial begin : monitor
    exp_pkt_t e;
    forever begin
      @(negedge clock);
      if (resetn) begin
        if (cnt_pending) begin
          check("pkt_count", 32'(pkt_count), exp_cnt(exp_pkts));
          check("err_count", 32'(err_count), exp_cnt(exp_errs));
          cnt_pending = 1'b0;
        end
        if (byte_valid) begin
          check("byte_expected", 32'(sb_byte.size() > 0), 1);
          if (sb_byte.size() > 0) check("byte_data", 32'(byte_data), 32'(sb_byte.pop_front()));
        end
        if (pkt_done) begin
          check("pkt_done_expected", 32'(sb_pkt.size() > 0), 1);
          if (sb_pkt.size() > 0) begin
            e = sb_pkt.pop_front();
            check("pkt_abort", 32'(pkt_abort), 32'(e.abort));
            check("parity_err", 32'(parity_err), 32'(e.perr));
            if (!e.abort) begin
              check("pkt_len", 32'(pkt_len), 32'(e.len));
              check("pkt_addr", 32'(pkt_addr), 32'(e.addr));
            end
            exp_pkts++;
            if (e.perr || e.abort) exp_errs++;
            cnt_pending = 1'b1;
          end
        end
      end
    end
  end

  // Builds one packet, queues it at the router and pushes its expectations.
  task automatic push_pkt(input int len, input int addr, input bit bad,
                          input int stall_pos, input int stall_n);
    logic [7:0] b, par;
    fbyte_t     fb;
    exp_pkt_t   e;
    bit         abort;
    abort = (stall_pos >= 0) && (stall_n >= STALL_MAX);
    par = 8'h00;
    for (int i = 0; i < len + 2; i++) begin
      if (i == 0)             b = {len[5:0], addr[1:0]};
      else if (i == len + 1)  b = par ^ {7'd0, bad};
      else                    b = 8'($urandom);
      if (i != len + 1) par ^= b;
      fb.data  = b;
      fb.stall = (i == stall_pos) ? stall_n : 0;
      fb.flush = abort;
      fb.last  = (i == len + 1);
      fifo.push_back(fb);
      if (!abort || i <= stall_pos) sb_byte.push_back(b);
    end
    e.len = len; e.addr = addr; e.perr = bad && !abort; e.abort = abort;
    sb_pkt.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb_pkt.size() > 0 || sb_byte.size() > 0 || fifo.size() > 0) && n < budget) begin
      @(negedge clock); #2;
      n++;
    end
    check("drain_pending", 32'(sb_pkt.size() + sb_byte.size()), 0);
    repeat (3) begin @(negedge clock); #2; end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_read_enb"},   32'(read_enb), 0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 0);
    check({tag, "_byte_data"},  32'(byte_data), 0);
    check({tag, "_pkt_done"},   32'(pkt_done), 0);
    check({tag, "_pkt_len"},    32'(pkt_len), 0);
    check({tag, "_pkt_addr"},   32'(pkt_addr), 0);
    check({tag, "_parity_err"}, 32'(parity_err), 0);
    check({tag, "_pkt_abort"},  32'(pkt_abort), 0);
    check({tag, "_pkt_count"},  32'(pkt_count), 0);
    check({tag, "_err_count"},  32'(err_count), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rd0, n;
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    check_zero_outputs("reset");
    resetn = 1'b1;
    @(negedge clock); #2;
    enable = 1'b1;

    // 1: len 8, good parity, continuous read burst
    rd0 = rd_count; max_run = 0;
    push_pkt(8, 0, 1'b0, -1, 0);
    wait_idle(500);
    check("t1_reads", 32'(rd_count - rd0), 10);
    check("t1_read_run", 32'(max_run), 10);

    // 2: corrupted parity
    push_pkt(8, 1, 1'b1, -1, 0);
    wait_idle(500);

    // 3: zero-length packet, header 8'h02 and parity 8'h02
    rd0 = rd_count;
    push_pkt(0, 2, 1'b0, -1, 0);
    wait_idle(500);
    check("t3_reads", 32'(rd_count - rd0), 2);

    // 4: two packets queued back to back
    rd0 = rd_count;
    push_pkt(4, 3, 1'b0, -1, 0);
    push_pkt(4, 1, 1'b0, -1, 0);
    wait_idle(500);
    check("t4_reads", 32'(rd_count - rd0), 12);

    // 5: stall of STALL_MAX-1 survives, stall of STALL_MAX aborts
    push_pkt(8, 3, 1'b0, 2, STALL_MAX - 1);
    wait_idle(500);
    push_pkt(8, 1, 1'b0, 2, STALL_MAX);
    wait_idle(500);
    check("t5_idle_no_read", 32'(read_enb), 0);

    // enable low: packet in progress completes, no new packet starts
    rd0 = rd_count; n = 0;
    push_pkt(10, 2, 1'b0, -1, 0);
    while (rd_count - rd0 < 3 && n < 200) begin @(negedge clock); #2; n++; end
    enable = 1'b0;
    while (sb_pkt.size() > 0 && n < 400) begin @(negedge clock); #2; n++; end
    rd0 = rd_count;
    push_pkt(5, 1, 1'b0, -1, 0);
    repeat (20) begin @(negedge clock); #2; end
    check("disabled_reads", 32'(rd_count - rd0), 0);
    enable = 1'b1;
    wait_idle(500);

    // 6: reset mid-payload discards the packet
    rd0 = rd_count; n = 0;
    push_pkt(20, 2, 1'b0, -1, 0);
    while (rd_count - rd0 < 5 && n < 200) begin @(negedge clock); #2; n++; end
    check("t6_reached_payload", 32'(rd_count - rd0 >= 5), 1);
    resetn = 1'b0;
    sb_pkt.delete(); sb_byte.delete();
    exp_pkts = 0; exp_errs = 0; cnt_pending = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(negedge clock); #2;
    resetn = 1'b1;
    push_pkt(6, 3, 1'b0, -1, 0);
    wait_idle(500);

    // Randomized traffic with stalls, aborts, parity errors and length extremes
    for (int p = 0; p < 40; p++) begin
      int len, addr, spos, sn, r;
      bit bad;
      r    = $urandom_range(0, 3);
      len  = (r == 0) ? 0 : (r == 1) ? 63 : $urandom_range(1, 62);
      addr = $urandom_range(0, 3);
      bad  = ($urandom_range(0, 3) == 0);
      spos = -1; sn = 0;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        spos = $urandom_range(0, len + 1);
        sn   = $urandom_range(1, STALL_MAX - 1);
      end else if (r == 2) begin
        spos = $urandom_range(0, len);
        sn   = STALL_MAX;
      end
      push_pkt(len, addr, bad, spos, sn);
      if ($urandom_range(0, 2) == 0) wait_idle(4000);
    end
    wait_idle(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
